// File: rtl/spi_byte_master.sv
// Byte-wide SPI master: shifts one byte out on MOSI (MSB first) while capturing MISO,
// then returns the received byte with a one-cycle valid strobe. Chip select lives elsewhere.
module spi_byte_master #(
    parameter int unsigned CLKS_PER_HALF_BIT = 2,
    parameter int unsigned SPI_MODE          = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] spitx,
    input  logic       spitxdv,
    output logic       spitxready,
    output logic [7:0] spirx,
    output logic       spirxdv,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    if (CLKS_PER_HALF_BIT < 1 || CLKS_PER_HALF_BIT > 255) begin : g_bad_half_bit
        $error("CLKS_PER_HALF_BIT must be in 1..255");
    end
    if (SPI_MODE > 3) begin : g_bad_mode
        $error("SPI_MODE must be in 0..3");
    end

    localparam logic       Cpol    = SPI_MODE[1];
    localparam logic       Cpha    = SPI_MODE[0];
    localparam logic [7:0] HalfMax = 8'(CLKS_PER_HALF_BIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e     state_q;
    logic [7:0] half_q;
    logic [4:0] edge_q;
    logic [7:0] tx_q;
    logic [7:0] rx_q;

    logic       accept;
    logic       wrap;
    logic [4:0] edge_nxt;
    logic       leading;
    logic       sample;
    logic       drive;
    logic [7:0] rx_shift;

    always_comb begin
        accept   = spitxdv && spitxready;
        wrap     = (half_q == HalfMax);
        edge_nxt = edge_q + 5'd1;
        leading  = edge_nxt[0];
        // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
        sample   = leading ^ Cpha;
        // CPHA=0 has bit 7 already set up at acceptance, so edge 16 must not shift again.
        drive    = !sample && (Cpha || (edge_nxt != 5'd16));
        rx_shift = {rx_q[6:0], miso};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            half_q     <= 8'd0;
            edge_q     <= 5'd0;
            tx_q       <= 8'd0;
            rx_q       <= 8'd0;
            spitxready <= 1'b1;
            spirx      <= 8'd0;
            spirxdv    <= 1'b0;
            sclk       <= Cpol;
            mosi       <= 1'b0;
        end else begin
            spirxdv <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    spitxready <= 1'b1;
                    state_q    <= StIdle;
                    if (accept) begin
                        state_q    <= StShift;
                        spitxready <= 1'b0;
                        half_q     <= 8'd0;
                        edge_q     <= 5'd0;
                        if (Cpha) begin
                            tx_q <= spitx;
                        end else begin
                            mosi <= spitx[7];
                            tx_q <= {spitx[6:0], 1'b0};
                        end
                    end
                end
                StShift: begin
                    half_q <= wrap ? 8'd0 : half_q + 8'd1;
                    if (wrap) begin
                        sclk   <= ~sclk;
                        edge_q <= edge_nxt;
                        if (sample) begin
                            rx_q <= rx_shift;
                        end
                        if (drive) begin
                            mosi <= tx_q[7];
                            tx_q <= {tx_q[6:0], 1'b0};
                        end
                        if (edge_nxt == 5'd16) begin
                            state_q    <= StDone;
                            spirxdv    <= 1'b1;
                            spitxready <= 1'b1;
                            spirx      <= sample ? rx_shift : rx_q;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_byte_master.sv
// Bench for spi_byte_master: four instances covering all SPI modes, each paired with a
// behavioural SPI slave that reacts to SCLK edges; timing expectations come from H and the mode.
module tb_spi_byte_master;

    // Per-instance H and mode: d0 = mode0/H2, d1 = mode3/H1, d2 = mode1/H3, d3 = mode2/H1.
    localparam logic [3:0][7:0] HS = {8'd1, 8'd3, 8'd1, 8'd2};
    localparam logic [3:0][1:0] MS = {2'd2, 2'd1, 2'd3, 2'd0};

    logic       clk;
    logic       rstn;
    logic [3:0] dv, ready, rxdv, sclk, mosi, miso, loop, slv_ld;
    logic [7:0] tx       [4];
    logic [7:0] rx       [4];
    logic [7:0] slv_byte [4];
    logic [7:0] slv_in   [4];
    logic       slv_miso [4];

    int n_vec;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_byte_master #(
            .CLKS_PER_HALF_BIT(int'(HS[g])),
            .SPI_MODE         (int'(MS[g]))
        ) u_dut (
            .clk       (clk),
            .rstn      (rstn),
            .spitx     (tx[g]),
            .spitxdv   (dv[g]),
            .spitxready(ready[g]),
            .spirx     (rx[g]),
            .spirxdv   (rxdv[g]),
            .sclk      (sclk[g]),
            .mosi      (mosi[g]),
            .miso      (miso[g])
        );

        assign miso[g] = loop[g] ? mosi[g] : slv_miso[g];

        // Slave: a toggle on slv_ld loads a new reply byte; otherwise act on each SCLK edge.
        logic [7:0] sh_out;
        logic       ld_seen = 1'b0;
        always @(sclk[g] or slv_ld[g]) begin
            if (slv_ld[g] !== ld_seen) begin
                ld_seen   = slv_ld[g];
                sh_out    = slv_byte[g];
                slv_in[g] = 8'h00;
                if (!MS[g][0]) begin
                    slv_miso[g] = sh_out[7];
                    sh_out      = {sh_out[6:0], 1'b0};
                end
            end else if ((sclk[g] !== MS[g][1]) ^ MS[g][0]) begin
                slv_in[g] = {slv_in[g][6:0], mosi[g]};
            end else begin
                slv_miso[g] = sh_out[7];
                sh_out      = {sh_out[6:0], 1'b0};
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic slave_load(input int d, input logic [7:0] b, input logic lp);
        slv_byte[d] = b;
        loop[d]     = lp;
        slv_ld[d]   = ~slv_ld[d];
    endtask

    // Called at a negedge: presents a request for the coming rising edge (cycle T).
    task automatic start(input int d, input logic [7:0] b, input logic [7:0] sl, input logic lp);
        chk("ready_before_start", 32'(ready[d]), 32'd1);
        tx[d] = b;
        dv[d] = 1'b1;
        slave_load(d, sl, lp);
    endtask

    // Observes cycles T+1 .. T+16H+1 of one byte and optionally chains the next request.
    task automatic expect_byte(input int d, input logic [7:0] sent, input logic [7:0] exp_rx,
                               input bit hold, input bit chain, input logic [7:0] nx_tx,
                               input logic [7:0] nx_sl, input logic nx_lp);
        int         h;
        logic       cpol, cpha, exp_s;
        int         bad_sclk, bad_busy, bad_rx;
        logic [7:0] rx_prev;
        h        = int'(HS[d]);
        cpol     = MS[d][1];
        cpha     = MS[d][0];
        bad_sclk = 0;
        bad_busy = 0;
        bad_rx   = 0;
        rx_prev  = rx[d];
        for (int c = 1; c <= 16 * h + 1; c++) begin
            @(negedge clk);
            if (c == 1 && !cpha) chk("mosi_setup", 32'(mosi[d]), 32'(sent[7]));
            if (c <= 16 * h) begin
                exp_s = cpol ^ 1'(((c - 1) / h) % 2);
                if (sclk[d] !== exp_s) bad_sclk++;
                if (ready[d] !== 1'b0 || rxdv[d] !== 1'b0) bad_busy++;
                if (rx[d] !== rx_prev) bad_rx++;
                if (hold) tx[d] = 8'($urandom);
                else dv[d] = 1'b0;
            end else begin
                chk("done_sclk_idle", 32'(sclk[d]), 32'(cpol));
                chk("done_ready", 32'(ready[d]), 32'd1);
                chk("done_rxdv", 32'(rxdv[d]), 32'd1);
                chk("done_rx_byte", 32'(rx[d]), 32'(exp_rx));
                chk("slave_saw_mosi", 32'(slv_in[d]), 32'(sent));
                if (chain) begin
                    tx[d] = nx_tx;
                    dv[d] = 1'b1;
                    slave_load(d, nx_sl, nx_lp);
                end else begin
                    dv[d] = 1'b0;
                end
            end
        end
        chk("sclk_waveform_bad_cycles", 32'(bad_sclk), 32'd0);
        chk("busy_flags_bad_cycles", 32'(bad_busy), 32'd0);
        chk("rx_changed_mid_byte", 32'(bad_rx), 32'd0);
        if (!chain) begin
            @(negedge clk);
            chk("rxdv_single_cycle", 32'(rxdv[d]), 32'd0);
            chk("ready_after_done", 32'(ready[d]), 32'd1);
        end
    endtask

    typedef struct {
        int         d;
        logic [7:0] tx;
        logic [7:0] sl;
        logic       lp;
        logic [7:0] exp_rx;
        bit         chain;
    } vec_t;

    vec_t vt[8];

    initial begin
        int         j, d, nchain, rxdv_hi;
        logic [7:0] txb, slb, nxt, nxs;
        logic       lp, nxl;

        n_vec  = 0;
        n_err  = 0;
        rstn   = 1'b0;
        dv     = '0;
        loop   = '0;
        slv_ld = '0;
        for (int i = 0; i < 4; i++) begin
            tx[i]       = 8'h00;
            slv_byte[i] = 8'h00;
        end

        vt[0] = '{0, 8'hA5, 8'h00, 1'b1, 8'hA5, 1'b0};
        vt[1] = '{0, 8'hC3, 8'h3C, 1'b0, 8'h3C, 1'b0};
        vt[2] = '{1, 8'h81, 8'h7E, 1'b0, 8'h7E, 1'b0};
        vt[3] = '{0, 8'h00, 8'hFF, 1'b0, 8'hFF, 1'b1};
        vt[4] = '{0, 8'h05, 8'hFA, 1'b0, 8'hFA, 1'b1};
        vt[5] = '{0, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[6] = '{2, 8'h96, 8'h69, 1'b0, 8'h69, 1'b0};
        vt[7] = '{3, 8'h4B, 8'hD2, 1'b0, 8'hD2, 1'b0};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("reset_ready", 32'(ready[i]), 32'd1);
            chk("reset_rxdv", 32'(rxdv[i]), 32'd0);
            chk("reset_rx", 32'(rx[i]), 32'd0);
            chk("reset_sclk", 32'(sclk[i]), 32'(MS[i][1]));
            chk("reset_mosi", 32'(mosi[i]), 32'd0);
        end
        rstn = 1'b1;
        @(negedge clk);

        // Directed table, including the back-to-back 0x00/0x05/0xFF sequence.
        for (int i = 0; i < 8; i++) begin
            j = (i < 7) ? i + 1 : i;
            if (i == 0 || !vt[i-1].chain) start(vt[i].d, vt[i].tx, vt[i].sl, vt[i].lp);
            if (vt[i].chain) begin
                expect_byte(vt[i].d, vt[i].tx, vt[i].exp_rx, 1'b0, 1'b1,
                            vt[j].tx, vt[j].sl, vt[j].lp);
            end else begin
                expect_byte(vt[i].d, vt[i].tx, vt[i].exp_rx, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
            end
        end

        // Request held high with spitx churning mid-byte; only the DONE-cycle value is taken.
        start(2, 8'h3A, 8'hC5, 1'b0);
        expect_byte(2, 8'h3A, 8'hC5, 1'b1, 1'b1, 8'h6D, 8'h12, 1'b0);
        expect_byte(2, 8'h6D, 8'h12, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Reset pulsed once edge 7 is visible on instance 2.
        start(2, 8'h33, 8'h99, 1'b0);
        for (int c = 1; c <= 7 * 3 + 1; c++) begin
            @(negedge clk);
            dv[2] = 1'b0;
        end
        rstn = 1'b0;
        #1;
        chk("midreset_sclk", 32'(sclk[2]), 32'(MS[2][1]));
        chk("midreset_ready", 32'(ready[2]), 32'd1);
        chk("midreset_rxdv", 32'(rxdv[2]), 32'd0);
        chk("midreset_rx", 32'(rx[2]), 32'd0);
        repeat (2) @(negedge clk);
        rstn    = 1'b1;
        rxdv_hi = 0;
        for (int c = 0; c < 16 * 3 + 2; c++) begin
            @(negedge clk);
            if (rxdv[2] !== 1'b0) rxdv_hi++;
        end
        chk("no_rxdv_after_abort", 32'(rxdv_hi), 32'd0);
        start(2, 8'h5A, 8'h5A, 1'b0);
        expect_byte(2, 8'h5A, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Random bytes and chains; reply is the slave byte, or the sent byte when looped back.
        for (int i = 0; i < 40; i++) begin
            d      = int'($urandom_range(0, 3));
            txb    = 8'($urandom);
            slb    = 8'($urandom);
            lp     = 1'($urandom_range(0, 1));
            nchain = int'($urandom_range(0, 2));
            start(d, txb, slb, lp);
            for (int k = 0; k <= nchain; k++) begin
                nxt = 8'($urandom);
                nxs = 8'($urandom);
                nxl = 1'($urandom_range(0, 1));
                expect_byte(d, txb, lp ? txb : slb, 1'b0, k < nchain, nxt, nxs, nxl);
                txb = nxt;
                slb = nxs;
                lp  = nxl;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
